// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache responder.
//   OP_READ / OP_WRITE : request opcode encoding, used on both the CPU
//                        and the backing-memory side
//   state_e            : responder FSM states
//   index_of / tag_of  : split a byte address into line index and tag.
//                        The result is returned at full width so that one
//                        helper serves any ADDR_W / INDEX_W; callers keep
//                        only the low bits they need.
package cache_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Widest address the split helpers accept.
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_e;

    // Line index: the word-address bits just above the byte offset.
    function automatic logic [MAX_ADDR_W-1:0] index_of(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    index_w
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = (MAX_ADDR_W'(1) << index_w) - MAX_ADDR_W'(1);
        return (addr >> 2) & mask;
    endfunction

    // Tag: everything above the index field.
    function automatic logic [MAX_ADDR_W-1:0] tag_of(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    index_w
    );
        return addr >> (index_w + 2);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Direct-mapped line storage: one valid bit, tag and data word per line.
//   clk, reset        : clock; synchronous active-high reset clears all
//                       valid bits (tag and data are left as they are)
//   rd_index          : combinational read port address
//   rd_valid/tag/data : contents of line rd_index
//   we                : write strobe; marks line wr_index valid and stores
//                       wr_tag / wr_data into it
module dcache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 26,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data carry no reset: a line is only trusted once its valid
    // bit has been set by a fill.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_responder.sv
// Blocking, direct-mapped, write-through, no-write-allocate cache with
// one-word lines, sitting between one CPU memory port and a backing memory.
//   clk, reset            : clock; synchronous active-high reset
//   req_*                 : CPU request channel (valid/ready), op 0=READ 1=WRITE
//   resp_*                : CPU response channel; resp_data is 0 for writes
//   mem_req_*             : backing-memory request channel (valid/ready)
//   mem_resp_valid/data   : backing-memory response, always accepted
//   hit_count, miss_count : lookup statistics, wrapping modulo 2^32
module dcache_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_op,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic [MAX_ADDR_W-1:0] idx_full, tag_full;
    logic [INDEX_W-1:0]    line_idx;
    logic [TAG_W-1:0]      line_tag;
    logic                  unused_split_bits;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              line_we;
    logic [DATA_W-1:0] line_wdata;

    // The lookup always works on the held address, so a request that
    // changes on the CPU side after the handshake cannot disturb it.
    always_comb begin
        idx_full = index_of(MAX_ADDR_W'(addr_q), INDEX_W);
        tag_full = tag_of(MAX_ADDR_W'(addr_q), INDEX_W);
        line_idx = idx_full[INDEX_W-1:0];
        line_tag = tag_full[TAG_W-1:0];
    end

    assign unused_split_bits = ^{idx_full[MAX_ADDR_W-1:INDEX_W],
                                 tag_full[MAX_ADDR_W-1:TAG_W]};

    assign hit = rd_valid && (rd_tag == line_tag);

    dcache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_index (line_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (line_we),
        .wr_index (line_idx),
        .wr_tag   (line_tag),
        .wr_data  (line_wdata)
    );

    // State register plus the control/status registers that reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_data_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Request holding register: plain data, only loaded on a handshake.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req_valid)      state_d = ST_LOOKUP;
            ST_LOOKUP:   state_d = (op_q == OP_READ && hit) ? ST_RESP : ST_MEM_REQ;
            ST_MEM_REQ:  if (mem_req_ready)  state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_resp_valid) state_d = ST_RESP;
            ST_RESP:     if (resp_ready)     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath, counter and line-store updates.
    always_comb begin
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_data_d  = resp_data_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        line_we      = 1'b0;
        line_wdata   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    hit_count_d = hit_count_q + 32'd1;
                end else begin
                    miss_count_d = miss_count_q + 32'd1;
                end
                if (op_q == OP_READ && hit) begin
                    resp_data_d = rd_data;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    if (op_q == OP_READ) begin
                        resp_data_d = mem_resp_data;
                        line_we     = 1'b1;
                        line_wdata  = mem_resp_data;
                    end else begin
                        // Write hits keep the line coherent with memory;
                        // write misses never allocate.
                        resp_data_d = '0;
                        line_we     = hit;
                        line_wdata  = wdata_q;
                    end
                end
            end
            default: ;
        endcase
        // A backing response landing in the reset cycle must not touch the
        // lines that reset is about to invalidate.
        if (reset) begin
            line_we = 1'b0;
        end
    end

    // Outputs. mem_req_valid is also masked by reset so an in-flight
    // backing request disappears in the reset cycle itself.
    always_comb begin
        req_ready     = (state_q == ST_IDLE);
        resp_valid    = (state_q == ST_RESP);
        resp_data     = resp_data_q;
        mem_req_valid = (state_q == ST_MEM_REQ) && !reset;
        mem_req_op    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        if (state_q == ST_MEM_REQ) begin
            mem_req_op    = op_q;
            mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_req_wdata = wdata_q;
        end
        hit_count  = hit_count_q;
        miss_count = miss_count_q;
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: a driver issues CPU requests and
// pushes the expected response (from a behavioural cache/memory model) into
// a queue; a monitor pops and compares on every response handshake, and a
// backing-memory responder checks the expected memory traffic.
module tb_dcache_responder;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 4;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_op;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    dcache_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_op     (mem_req_op),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [31:0] hits;
        logic [31:0] misses;
        bit          is_hit;
        int          acc_cyc;
    } exp_resp_t;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_mem_t;

    exp_resp_t resp_q[$];
    exp_mem_t  memq[$];

    logic [31:0] mem [int unsigned];   // backing memory, keyed by word address

    bit          m_valid [16];         // which word each line currently holds
    logic [25:0] m_tag   [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic logic [31:0] mem_rd(logic [31:0] byte_addr);
        int unsigned key;
        key = byte_addr >> 2;
        if (mem.exists(key)) return mem[key];
        return (key * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Called at the moment a request is accepted; the cache is blocking, so
    // every earlier transaction has already completed.
    function automatic void model_accept(logic op, logic [31:0] addr, logic [31:0] wd, int acc);
        int        idx;
        logic [25:0] tag;
        bit        hit;
        exp_resp_t e;
        exp_mem_t  m;
        idx = int'(addr[5:2]);
        tag = addr[31:6];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) m_hits++; else m_misses++;
        e.data    = (op == 1'b1) ? 32'h0 : mem_rd(addr);
        e.hits    = m_hits;
        e.misses  = m_misses;
        e.is_hit  = hit && (op == 1'b0);
        e.acc_cyc = acc;
        resp_q.push_back(e);
        if (!(hit && op == 1'b0)) begin
            m.op    = op;
            m.addr  = addr & ~32'h3;
            m.wdata = wd;
            memq.push_back(m);
        end
        if (op == 1'b0 && !hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
    endfunction

    // ---------------- response monitor ----------------
    int          resp_stall_left = 0;
    bit          mon_prev_stall  = 0;
    bit          mon_prev_rv     = 0;
    int          mon_rise_cyc    = 0;
    logic [31:0] mon_prev_data, mon_prev_hits, mon_prev_misses;

    initial begin
        exp_resp_t e;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_stall = 0;
                mon_prev_rv    = 0;
                resp_ready     = 1'b0;
            end else begin
                if (mon_prev_stall) begin
                    check("stall_resp_valid", resp_valid, 1);
                    check("stall_resp_data", resp_data, mon_prev_data);
                    check("stall_req_ready", req_ready, 0);
                    check("stall_hit_count", hit_count, mon_prev_hits);
                    check("stall_miss_count", miss_count, mon_prev_misses);
                end
                if (resp_valid && !mon_prev_rv) mon_rise_cyc = cyc;
                mon_prev_rv = resp_valid;
                if (resp_valid && resp_stall_left > 0) begin
                    resp_ready = 1'b0;
                    resp_stall_left--;
                end else begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                if (resp_valid && resp_ready) begin
                    if (resp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got data 0x%08h, required no response", resp_data);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_data", resp_data, e.data);
                        check("hit_count", hit_count, e.hits);
                        check("miss_count", miss_count, e.misses);
                        // Earliest consuming edge relative to the accept edge.
                        if (e.is_hit) check("hit_latency_edges", mon_rise_cyc + 1 - e.acc_cyc, 2);
                    end
                end
                mon_prev_stall  = resp_valid && !resp_ready;
                mon_prev_data   = resp_data;
                mon_prev_hits   = hit_count;
                mon_prev_misses = miss_count;
            end
        end
    end

    // ---------------- backing memory ----------------
    int          mem_stall_left = 0;
    bit          mem_hold       = 0;
    int          mem_hs_cnt     = 0;
    bit          bk_pending     = 0;
    int          bk_delay       = 0;
    logic [31:0] bk_data;
    bit          bk_prev_stall  = 0;
    logic        bk_op;
    logic [31:0] bk_addr, bk_wdata;

    initial begin
        exp_mem_t m;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (bk_pending && !mem_hold) begin
                if (bk_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = bk_data;
                    bk_pending     = 0;
                end else begin
                    bk_delay--;
                end
            end
            if (bk_prev_stall && !reset) begin
                check("mem_req_valid_held", mem_req_valid, 1);
                check("mem_req_op_held", mem_req_op, bk_op);
                check("mem_req_addr_held", mem_req_addr, bk_addr);
                check("mem_req_wdata_held", mem_req_wdata, bk_wdata);
            end
            bk_prev_stall = 0;
            if (mem_req_valid) begin
                if (mem_stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    mem_stall_left--;
                end else begin
                    mem_req_ready = ($urandom_range(0, 2) != 0);
                end
                if (mem_req_ready) begin
                    mem_hs_cnt++;
                    if (memq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h op %0d, required none", mem_req_addr, mem_req_op);
                    end else begin
                        m = memq.pop_front();
                        check("mem_req_op", mem_req_op, m.op);
                        check("mem_req_addr", mem_req_addr, m.addr);
                        if (m.op == 1'b1) begin
                            check("mem_req_wdata", mem_req_wdata, m.wdata);
                            mem[m.addr >> 2] = m.wdata;
                        end
                    end
                    bk_data    = (mem_req_op == 1'b1) ? $urandom : mem_rd(mem_req_addr);
                    bk_pending = 1;
                    bk_delay   = $urandom_range(0, 2);
                end else begin
                    bk_prev_stall = 1;
                    bk_op         = mem_req_op;
                    bk_addr       = mem_req_addr;
                    bk_wdata      = mem_req_wdata;
                end
            end else begin
                mem_req_ready = $urandom_range(0, 1) != 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(logic op, logic [31:0] addr, logic [31:0] wd);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got req_ready 0 for %0d cycles, required 1", waited);
            req_valid = 1'b0;
            return;
        end
        model_accept(op, addr, wd, cyc + 1);
        @(negedge clk);
        // Scramble the request lines: the held copy must be what is used.
        req_valid = 1'b0;
        req_op    = $urandom_range(0, 1) != 0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int waited = 0;
        while (resp_q.size() != 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (resp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", resp_q.size());
        end
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_op", mem_req_op, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_mem_req_wdata", mem_req_wdata, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
    endtask

    initial begin
        int snap;
        int waited;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        mem[32'h40 >> 2] = 32'h0000_1234;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state();

        // Read miss then read hit of the same word.
        do_req(1'b0, 32'h40, 32'h0);
        do_req(1'b0, 32'h40, 32'h0);
        // Write hit goes through to memory and updates the line.
        do_req(1'b1, 32'h40, 32'h0000_BEEF);
        do_req(1'b0, 32'h40, 32'h0);
        // Write miss does not allocate.
        do_req(1'b1, 32'h80, 32'h0000_0777);
        do_req(1'b0, 32'h80, 32'h0);
        // Conflict on index 0: 0x440 evicts 0x40.
        do_req(1'b0, 32'h40, 32'h0);
        do_req(1'b0, 32'h440, 32'h0);
        do_req(1'b0, 32'h40, 32'h0);
        // Backing request held off, then a stalled hit response.
        mem_stall_left = 5;
        do_req(1'b0, 32'h200, 32'h0);
        drain();
        resp_stall_left = 4;
        do_req(1'b0, 32'h200, 32'h0);
        drain();

        // Reset while waiting for the backing response.
        mem_hold = 1;
        snap     = mem_hs_cnt;
        do_req(1'b0, 32'h8C0, 32'h0);
        waited = 0;
        while (mem_hs_cnt == snap && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("mem_wait_reached", (mem_hs_cnt != snap) ? 1 : 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        resp_q.delete();
        memq.delete();
        model_reset();
        check_reset_state();
        mem_hold = 0;
        repeat (6) @(negedge clk);
        check("late_resp_ignored_valid", resp_valid, 0);
        check("late_resp_ignored_ready", req_ready, 1);
        check("late_resp_ignored_data", resp_data, 0);
        do_req(1'b0, 32'h40, 32'h0);
        drain();

        // Randomized traffic over a small address pool to mix hits and misses.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) mem_stall_left = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) resp_stall_left = $urandom_range(1, 4);
            do_req($urandom_range(0, 1) != 0, a, $urandom);
        end
        drain();
        check("final_hit_count", hit_count, m_hits);
        check("final_miss_count", miss_count, m_misses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
